// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one backing-memory port between I-cache and D-cache miss paths, D first.
// Optional instruction starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int LINE_W       = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req_valid,
    input  logic [31:0]       ic_req_addr,
    output logic              ic_req_ready,
    output logic              ic_resp_valid,
    output logic [LINE_W-1:0] ic_resp_data,
    input  logic              dc_req_valid,
    input  logic              dc_req_we,
    input  logic [31:0]       dc_req_addr,
    input  logic [LINE_W-1:0] dc_req_wdata,
    output logic              dc_req_ready,
    output logic              dc_resp_valid,
    output logic [LINE_W-1:0] dc_resp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [31:0]       mem_req_addr,
    output logic [LINE_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [LINE_W-1:0] mem_resp_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state;
    logic   own_d;
    logic   force_i;
    logic   idle_ok;
    logic   grant_d;
    logic   grant_i;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] dstreak;

    assign force_i = (dstreak == SW'(STARVE_LIMIT));

    // Counts D grants that bypassed a waiting instruction request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dstreak <= '0;
        end else if (state == IDLE) begin
            if (grant_i) begin
                dstreak <= '0;
            end else if (grant_d && ic_req_valid) begin
                if (dstreak != SW'(STARVE_LIMIT)) begin
                    dstreak <= dstreak + SW'(1);
                end
            end else if (!ic_req_valid) begin
                dstreak <= '0;
            end
        end
    end
`else
    assign force_i = 1'b0;
`endif

    // Gating with reset keeps the readies low while reset is held.
    assign idle_ok = (state == IDLE) && reset;
    assign grant_d = idle_ok && dc_req_valid && !(ic_req_valid && force_i);
    assign grant_i = idle_ok && ic_req_valid && (!dc_req_valid || force_i);

    assign ic_req_ready = grant_i;
    assign dc_req_ready = grant_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            own_d         <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            ic_resp_valid <= 1'b0;
            ic_resp_data  <= '0;
            dc_resp_valid <= 1'b0;
            dc_resp_data  <= '0;
            busy          <= 1'b0;
        end else begin
            ic_resp_valid <= 1'b0;
            dc_resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        own_d         <= 1'b1;
                        mem_req_we    <= dc_req_we;
                        mem_req_addr  <= dc_req_addr;
                        mem_req_wdata <= dc_req_wdata;
                        mem_req_valid <= 1'b1;
                        busy          <= 1'b1;
                        state         <= REQ;
                    end else if (grant_i) begin
                        own_d         <= 1'b0;
                        mem_req_we    <= 1'b0;
                        mem_req_addr  <= ic_req_addr;
                        mem_req_wdata <= '0;
                        mem_req_valid <= 1'b1;
                        busy          <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        if (own_d) begin
                            dc_resp_valid <= 1'b1;
                            dc_resp_data  <= mem_resp_data;
                        end else begin
                            ic_resp_valid <= 1'b1;
                            ic_resp_data  <= mem_resp_data;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    mem_req_valid <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter; define ARB_STARVE_GUARD_EN for guard builds.
module tb_mem_arbiter;
    localparam int LINE_W = 128;
    localparam int LIMIT  = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              ic_req_valid, ic_req_ready, ic_resp_valid;
    logic [31:0]       ic_req_addr;
    logic [LINE_W-1:0] ic_resp_data;
    logic              dc_req_valid, dc_req_we, dc_req_ready, dc_resp_valid;
    logic [31:0]       dc_req_addr;
    logic [LINE_W-1:0] dc_req_wdata, dc_resp_data;
    logic              mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid, busy;
    logic [31:0]       mem_req_addr;
    logic [LINE_W-1:0] mem_req_wdata, mem_resp_data;

    int n_checks = 0;
    int n_fail   = 0;
    logic [LINE_W-1:0] mem_model [logic [31:0]];

    always #5 clk = ~clk;

    mem_arbiter #(.LINE_W(LINE_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_we(dc_req_we), .dc_req_addr(dc_req_addr),
        .dc_req_wdata(dc_req_wdata), .dc_req_ready(dc_req_ready),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .busy(busy)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ic_req_valid = 0; ic_req_addr = '0;
        dc_req_valid = 0; dc_req_we = 0; dc_req_addr = '0; dc_req_wdata = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
    endtask

    // Memory side of one transaction, starting in REQ; returns at the cycle the response is visible.
    task automatic serve_mem(input logic [LINE_W-1:0] data, input int rdly, input int pdly);
        repeat (rdly) begin mem_req_ready = 0; tick(); end
        mem_req_ready = 1; tick(); mem_req_ready = 0;
        repeat (pdly) tick();
        mem_resp_valid = 1; mem_resp_data = data; tick(); mem_resp_valid = 0;
    endtask

    task automatic test_reset();
        reset = 0; idle_inputs(); tick();
        n_checks++; if ({ic_req_ready, dc_req_ready, mem_req_valid, ic_resp_valid, dc_resp_valid, busy, mem_req_we} !== 7'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0", {ic_req_ready, dc_req_ready, mem_req_valid, ic_resp_valid, dc_resp_valid, busy, mem_req_we}); end
        n_checks++; if ({mem_req_addr, mem_req_wdata, ic_resp_data, dc_resp_data} !== '0) begin
            n_fail++; $display("FAIL reset_payload: addr %h wdata %h icd %h dcd %h want 0", mem_req_addr, mem_req_wdata, ic_resp_data, dc_resp_data); end
        reset = 1; tick();
    endtask

    task automatic test_single_read();
        ic_req_valid = 1; ic_req_addr = 32'h100; #1;
        n_checks++; if ({ic_req_ready, dc_req_ready} !== 2'b10) begin
            n_fail++; $display("FAIL read_ready: got %b want 10", {ic_req_ready, dc_req_ready}); end
        tick(); ic_req_valid = 0; ic_req_addr = 32'hdead_beef;
        n_checks++; if ({mem_req_valid, mem_req_we, busy} !== 3'b101 || mem_req_addr !== 32'h100) begin
            n_fail++; $display("FAIL read_mem_req: v/we/busy %b addr %h want 101 100", {mem_req_valid, mem_req_we, busy}, mem_req_addr); end
        serve_mem({16{8'hA5}}, 0, 1);
        n_checks++; if ({ic_resp_valid, dc_resp_valid, busy} !== 3'b100 || ic_resp_data !== {16{8'hA5}}) begin
            n_fail++; $display("FAIL read_resp: flags %b data %h want 100 a5..", {ic_resp_valid, dc_resp_valid, busy}, ic_resp_data); end
        tick();
        n_checks++; if ({ic_resp_valid, dc_resp_valid} !== 2'b00) begin
            n_fail++; $display("FAIL read_resp_pulse: got %b want 00", {ic_resp_valid, dc_resp_valid}); end
    endtask

    task automatic test_write_stall();
        dc_req_valid = 1; dc_req_we = 1; dc_req_addr = 32'h40; dc_req_wdata = 128'h1234; #1;
        n_checks++; if ({ic_req_ready, dc_req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL write_ready: got %b want 01", {ic_req_ready, dc_req_ready}); end
        tick(); dc_req_valid = 0; dc_req_we = 0; dc_req_addr = $urandom; dc_req_wdata = {4{$urandom}};
        for (int i = 0; i < 3; i++) begin
            mem_req_ready = 0;
            n_checks++; if ({mem_req_valid, mem_req_we} !== 2'b11 || mem_req_addr !== 32'h40 || mem_req_wdata !== 128'h1234) begin
                n_fail++; $display("FAIL write_stall%0d: v/we %b addr %h wdata %h want 11 40 1234", i, {mem_req_valid, mem_req_we}, mem_req_addr, mem_req_wdata); end
            tick();
        end
        serve_mem({4{$urandom}}, 0, 0);
        n_checks++; if ({ic_resp_valid, dc_resp_valid} !== 2'b01) begin
            n_fail++; $display("FAIL write_ack: got %b want 01", {ic_resp_valid, dc_resp_valid}); end
        tick();
        n_checks++; if (dc_resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL write_ack_pulse: got %b want 0", dc_resp_valid); end
    endtask

    task automatic test_both_valid();
        logic [LINE_W-1:0] d1, d2;
        d1 = {4{$urandom}}; d2 = {4{$urandom}};
        ic_req_valid = 1; ic_req_addr = 32'h200;
        dc_req_valid = 1; dc_req_we = 0; dc_req_addr = 32'h300; #1;
        n_checks++; if ({ic_req_ready, dc_req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL both_ready: got %b want 01", {ic_req_ready, dc_req_ready}); end
        tick(); dc_req_valid = 0;
        n_checks++; if (mem_req_addr !== 32'h300) begin
            n_fail++; $display("FAIL both_d_addr: got %h want 300", mem_req_addr); end
        serve_mem(d1, 0, 0);
        n_checks++; if (dc_resp_valid !== 1'b1 || dc_resp_data !== d1) begin
            n_fail++; $display("FAIL both_d_resp: v %b data %h want 1 %h", dc_resp_valid, dc_resp_data, d1); end
        #1;
        n_checks++; if ({ic_req_ready, dc_req_ready} !== 2'b10) begin
            n_fail++; $display("FAIL both_i_next: got %b want 10", {ic_req_ready, dc_req_ready}); end
        tick(); ic_req_valid = 0;
        n_checks++; if (mem_req_addr !== 32'h200 || mem_req_we !== 1'b0) begin
            n_fail++; $display("FAIL both_i_addr: addr %h we %b want 200 0", mem_req_addr, mem_req_we); end
        serve_mem(d2, 1, 1);
        n_checks++; if (ic_resp_valid !== 1'b1 || ic_resp_data !== d2) begin
            n_fail++; $display("FAIL both_i_resp: v %b data %h want 1 %h", ic_resp_valid, ic_resp_data, d2); end
    endtask

    task automatic test_starvation();
        bit exp_i;
        ic_req_valid = 1; ic_req_addr = 32'h500;
        dc_req_valid = 1; dc_req_we = 0; dc_req_addr = 32'h600;
        for (int k = 0; k < 10; k++) begin
            #1;
            exp_i = GUARD && ((k % (LIMIT + 1)) == LIMIT);
            n_checks++; if ({ic_req_ready, dc_req_ready} !== {exp_i, !exp_i}) begin
                n_fail++; $display("FAIL starve_grant%0d: got %b want %b", k, {ic_req_ready, dc_req_ready}, {exp_i, !exp_i}); end
            tick();
            serve_mem({4{$urandom}}, 0, 0);
        end
        idle_inputs(); tick();
    endtask

    task automatic test_spurious_resp();
        mem_resp_valid = 1; mem_resp_data = {4{$urandom}}; tick(); mem_resp_valid = 0;
        n_checks++; if ({ic_resp_valid, dc_resp_valid, busy, mem_req_valid} !== 4'b0) begin
            n_fail++; $display("FAIL spurious_idle: got %b want 0000", {ic_resp_valid, dc_resp_valid, busy, mem_req_valid}); end
        dc_req_valid = 1; dc_req_we = 0; dc_req_addr = 32'h80; tick(); dc_req_valid = 0;
        mem_resp_valid = 1; tick(); mem_resp_valid = 0;
        n_checks++; if ({dc_resp_valid, mem_req_valid, busy} !== 3'b011) begin
            n_fail++; $display("FAIL spurious_req: got %b want 011", {dc_resp_valid, mem_req_valid, busy}); end
        serve_mem({4{$urandom}}, 0, 0);
        tick();
    endtask

    task automatic test_reset_mid();
        logic [LINE_W-1:0] d;
        d = {4{$urandom}};
        dc_req_valid = 1; dc_req_we = 1; dc_req_addr = 32'h700; dc_req_wdata = {4{$urandom}};
        tick(); dc_req_valid = 0;
        mem_req_ready = 1; tick(); mem_req_ready = 0;
        #2 reset = 0; #1;
        n_checks++; if ({ic_req_ready, dc_req_ready, mem_req_valid, mem_req_we, ic_resp_valid, dc_resp_valid, busy} !== 7'b0 || mem_req_addr !== '0 || mem_req_wdata !== '0) begin
            n_fail++; $display("FAIL midreset_outputs: flags %b addr %h wdata %h want 0", {ic_req_ready, dc_req_ready, mem_req_valid, mem_req_we, ic_resp_valid, dc_resp_valid, busy}, mem_req_addr, mem_req_wdata); end
        tick(); reset = 1;
        mem_resp_valid = 1; mem_resp_data = {4{$urandom}}; tick(); mem_resp_valid = 0;
        n_checks++; if ({ic_resp_valid, dc_resp_valid, busy} !== 3'b0) begin
            n_fail++; $display("FAIL midreset_late_resp: got %b want 000", {ic_resp_valid, dc_resp_valid, busy}); end
        ic_req_valid = 1; ic_req_addr = 32'h800; #1;
        n_checks++; if (ic_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL midreset_fresh_ready: got %b want 1", ic_req_ready); end
        tick(); ic_req_valid = 0;
        serve_mem(d, 0, 0);
        n_checks++; if (ic_resp_valid !== 1'b1 || ic_resp_data !== d) begin
            n_fail++; $display("FAIL midreset_fresh_resp: v %b data %h want 1 %h", ic_resp_valid, ic_resp_data, d); end
        tick();
    endtask

    // Random requesters and memory against a transaction-level model of the arbiter.
    task automatic test_random(input int cycles);
        int phase = 0, delay = 0, streak = 0;
        bit cur_d = 0, cur_we = 0, exp_irv, exp_drv, exp_chk = 0, exp_gi, exp_gd, force_i;
        bit ev_gi = 0, ev_gd = 0, ev_acc = 0, ev_resp = 0;
        logic [31:0] cur_addr = '0;
        logic [LINE_W-1:0] cur_wdata = '0, exp_data = '0, got;
        for (int c = 0; c < cycles; c++) begin
            exp_irv = 0; exp_drv = 0;
            if (ev_resp) begin
                phase = 0; exp_irv = !cur_d; exp_drv = cur_d; exp_chk = !cur_we;
                if (cur_we) mem_model[cur_addr] = cur_wdata;
            end
            if (ev_acc) begin phase = 2; delay = $urandom_range(0, 2); end
            if (ev_gd) begin
                phase = 1; cur_d = 1; cur_we = dc_req_we; cur_addr = dc_req_addr; cur_wdata = dc_req_wdata; dc_req_valid = 0;
            end
            if (ev_gi) begin phase = 1; cur_d = 0; cur_we = 0; cur_addr = ic_req_addr; ic_req_valid = 0; end

            n_checks++; if ({mem_req_valid, busy} !== {phase == 1, phase != 0}) begin
                n_fail++; $display("FAIL rand_state c%0d: v/busy %b want %b", c, {mem_req_valid, busy}, {phase == 1, phase != 0}); end
            n_checks++; if ({ic_resp_valid, dc_resp_valid} !== {exp_irv, exp_drv}) begin
                n_fail++; $display("FAIL rand_resp_valid c%0d: got %b want %b", c, {ic_resp_valid, dc_resp_valid}, {exp_irv, exp_drv}); end
            if ((exp_irv || exp_drv) && exp_chk) begin
                got = exp_irv ? ic_resp_data : dc_resp_data;
                n_checks++; if (got !== exp_data) begin
                    n_fail++; $display("FAIL rand_resp_data c%0d: got %h want %h", c, got, exp_data); end
            end
            if (phase == 1) begin
                n_checks++; if (mem_req_addr !== cur_addr || mem_req_we !== cur_we || (cur_we && mem_req_wdata !== cur_wdata)) begin
                    n_fail++; $display("FAIL rand_mem_req c%0d: addr %h we %b wdata %h want %h %b %h", c, mem_req_addr, mem_req_we, mem_req_wdata, cur_addr, cur_we, cur_wdata); end
            end

            if (dc_req_valid && $urandom_range(0, 15) == 0) dc_req_valid = 0;
            if (!ic_req_valid && $urandom_range(0, 3) == 0) begin
                ic_req_valid = 1; ic_req_addr = 32'($urandom_range(0, 15)) << 4;
            end
            if (!dc_req_valid && $urandom_range(0, 2) == 0) begin
                dc_req_valid = 1; dc_req_we = 1'($urandom_range(0, 1));
                dc_req_addr = 32'($urandom_range(0, 15)) << 4; dc_req_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            mem_req_ready = 1'($urandom_range(0, 1));
            mem_resp_valid = 0; mem_resp_data = {4{$urandom}};
            if (phase == 2) begin
                if (delay == 0) begin
                    mem_resp_valid = 1;
                    if (!cur_we) mem_resp_data = mem_model.exists(cur_addr) ? mem_model[cur_addr] : {4{cur_addr}};
                    exp_data = mem_resp_data;
                end else delay--;
            end else if ($urandom_range(0, 7) == 0) mem_resp_valid = 1;
            #1;

            exp_gi = 0; exp_gd = 0;
            if (phase == 0) begin
                force_i = GUARD && streak >= LIMIT && ic_req_valid && dc_req_valid;
                if (dc_req_valid && !force_i) exp_gd = 1;
                else if (ic_req_valid) exp_gi = 1;
                if (exp_gi || !ic_req_valid) streak = 0;
                else if (exp_gd) streak = (streak < LIMIT) ? streak + 1 : LIMIT;
            end
            n_checks++; if ({ic_req_ready, dc_req_ready} !== {exp_gi, exp_gd}) begin
                n_fail++; $display("FAIL rand_grant c%0d: got %b want %b", c, {ic_req_ready, dc_req_ready}, {exp_gi, exp_gd}); end
            ev_gi = exp_gi; ev_gd = exp_gd;
            ev_acc = (phase == 1) && mem_req_ready;
            ev_resp = (phase == 2) && mem_resp_valid;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        reset = 0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_write_stall();
        test_both_valid();
        test_starvation();
        test_spurious_resp();
        test_reset_mid();
        test_random(800);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single backing-memory port between the instruction-cache miss path and the data-cache miss/writeback path of the Riscv151 core. It accepts one line-sized request at a time from either requester, forwards it to memory with a valid/ready handshake, and returns the response to the owner. Data requests have priority. An optional starvation guard bounds how long instruction fetch can be locked out.

## Interface
Parameters:
- LINE_W, 128: memory line width in bits.
- STARVE_LIMIT, 4: consecutive data grants allowed while an instruction request waits (guard builds only).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ic_req_valid  in  1  instruction-side read request.
- ic_req_addr  in  32  line address.
- ic_req_ready  out  1  request accepted this cycle.
- ic_resp_valid  out  1  one-cycle pulse; ic_resp_data is valid.
- ic_resp_data  out  LINE_W  returned line.
- dc_req_valid  in  1  data-side request.
- dc_req_we  in  1  1 = write line, 0 = read line.
- dc_req_addr  in  32  line address.
- dc_req_wdata  in  LINE_W  write data.
- dc_req_ready  out  1  request accepted this cycle.
- dc_resp_valid  out  1  one-cycle pulse; read data, or write acknowledge.
- dc_resp_data  out  LINE_W  returned line; don't-care on write ack.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_we  out  1  write flag.
- mem_req_addr  out  32  address.
- mem_req_wdata  out  LINE_W  write data.
- mem_resp_valid  in  1  memory response; given once per request, reads and writes alike.
- mem_resp_data  in  LINE_W  response data.
- busy  out  1  high in any state except IDLE.

## Operation
- FSM states: IDLE, REQ, WAIT. Owner register `own` holds I or D.
- IDLE grant decision (combinational):
  - dc_req_valid alone → grant D.
  - ic_req_valid alone → grant I.
  - Both valid → grant D, except when the starvation guard forces I.
  - Only the granted requester sees its `*_req_ready` high.
  - On grant, addr, we and wdata are captured (I-side: we=0) and `own` is set.
  - Next state is REQ.
- REQ: mem_req_valid=1, driven only from the captured registers. On mem_req_ready, next state is WAIT.
- WAIT: on mem_resp_valid, mem_resp_data is registered into the owner's resp_data, the owner's resp_valid pulses for one cycle, and next state is IDLE.
- mem_resp_valid in IDLE or REQ is ignored.
- Requesters must hold their valid and payload until ready. Dropping valid before ready is legal; nothing is captured in that case.
- Reset values:
  - state = IDLE; all valid/ready outputs = 0; busy = 0.
  - mem_req_* payload, resp_data and the streak counter = 0.
- Reset asserted mid-transaction: the transaction is abandoned immediately. No resp pulse is issued, and memory must be reset alongside.

## Timing
- Request accepted at edge N (ready high in cycle N) → mem_req_valid high from cycle N+1.
- mem_req_ready sampled in cycle M → WAIT from M+1.
- mem_resp_valid in cycle K → resp_valid high in cycle K+1 only.
- The earliest next grant is also cycle K+1, since IDLE is re-entered at K+1.
- Minimum turnaround is 4 cycles: accept, REQ with ready=1, WAIT with response, resp/IDLE.
- Ready outputs are combinational from state and request valids. All other outputs are registered.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - Counter `dstreak`, width $clog2(STARVE_LIMIT+1), saturating.
  - Incremented on each D grant made while ic_req_valid=1.
  - Cleared on any I grant, and in IDLE when ic_req_valid=0.
  - When dstreak==STARVE_LIMIT and both requesters are valid, I is granted.
- Undefined: strict data priority; the counter logic is absent.

## Test plan
- Single I read to addr 0x100, mem_req_ready=1 immediately, response 0xA5..A5 two cycles later → mem_req_addr=0x100, we=0; ic_resp_valid for exactly one cycle with the data; dc_resp_valid stays 0.
- D write to addr 0x40 with wdata=0x1234, mem_req_ready held low 3 cycles → mem_req_valid stays high with a stable payload for all 3 cycles; dc_resp_valid pulses once after mem_resp_valid.
- I and D valid together in IDLE → dc_req_ready=1, ic_req_ready=0; I is served next.
- Guard enabled, STARVE_LIMIT=4, I held valid, D valid continuously → exactly 4 D transactions, then 1 I transaction, then D resumes. Guard disabled → I is never granted while D is valid.
- mem_resp_valid pulsed while in IDLE → no resp pulse and no state change.
- reset low during WAIT → all outputs return to reset values asynchronously; a later mem_resp_valid is ignored; a fresh request completes normally.
